// File: rtl/lbus_pkg.sv
// Shared LBUS definitions: segment geometry and the packed segment/word types.
package lbus_pkg;

  localparam int LBUS_SEG_BYTES = 16;
  localparam int LBUS_SEG_CNT   = 4;

  typedef struct packed {
    logic [LBUS_SEG_BYTES*8-1:0] data;
    logic                        ena;
    logic                        sop;
    logic                        eop;
    logic                        err;
    logic [3:0]                  mty;
  } lbus_seg_t;

  typedef lbus_seg_t [LBUS_SEG_CNT-1:0] lbus_word_t;

endpackage

// File: rtl/lbus_tx_skid_fifo.sv
// Skid FIFO for framed LBUS words; an entry becomes readable one cycle after it is written.
module lbus_tx_skid_fifo
  import lbus_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type word_t = lbus_word_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  word_t din_i,
  input  logic  pop_i,
  output word_t dout_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  // A lone entry written on the previous edge is not yet visible to the reader.
  assign empty_o = (cnt_q == '0) || ((cnt_q == (AW+1)'(1)) && push_q);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      push_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q  <= cnt_d;
      push_q <= do_push;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/axi_to_lbus.sv
// Frames 512-bit AXI4-Stream beats onto a 4-segment LBUS word through a skid FIFO.
// Define AXI_TO_LBUS_ERR_EN to add s_axis_tuser and err marking of malformed packets.
module axi_to_lbus
  import lbus_pkg::*;
#(
  parameter int SKID_DEPTH = 4
) (
  input  logic         tx_clk,
  input  logic         tx_resetn,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
`ifdef AXI_TO_LBUS_ERR_EN
  input  logic         s_axis_tuser,
`endif
  input  logic         tx_rdyout,
  input  logic         tx_ovfout,
  input  logic         tx_unfout,
  output logic [127:0] tx_datain0,
  output logic         tx_enain0,
  output logic         tx_sopin0,
  output logic         tx_eopin0,
  output logic         tx_errin0,
  output logic [3:0]   tx_mtyin0,
  output logic [127:0] tx_datain1,
  output logic         tx_enain1,
  output logic         tx_sopin1,
  output logic         tx_eopin1,
  output logic         tx_errin1,
  output logic [3:0]   tx_mtyin1,
  output logic [127:0] tx_datain2,
  output logic         tx_enain2,
  output logic         tx_sopin2,
  output logic         tx_eopin2,
  output logic         tx_errin2,
  output logic [3:0]   tx_mtyin2,
  output logic [127:0] tx_datain3,
  output logic         tx_enain3,
  output logic         tx_sopin3,
  output logic         tx_eopin3,
  output logic         tx_errin3,
  output logic [3:0]   tx_mtyin3,
  output logic         ovf_sticky,
  output logic         unf_sticky
);

  logic       accept, pop;
  logic       in_pkt_q, in_pkt_d;
  logic       active_q;
  logic       ovf_q, unf_q;
  logic [6:0] nbytes;
  logic [1:0] eseg;
  logic [3:0] emty;
  logic       err_eop, keep_zero;
  logic       fifo_full, fifo_empty;
  lbus_word_t word_d, fifo_dout, lbus_q, lbus_d;

  assign s_axis_tready = active_q && !fifo_full;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign pop           = tx_rdyout && !fifo_empty;

`ifdef AXI_TO_LBUS_ERR_EN
  logic err_acc_q, err_acc_d, keep_bad;

  always_comb begin
    keep_zero = (s_axis_tkeep == '0);
    if (s_axis_tlast) keep_bad = ((s_axis_tkeep & (s_axis_tkeep + 64'd1)) != '0);
    else              keep_bad = (s_axis_tkeep != '1);
    err_eop   = err_acc_q | s_axis_tuser | keep_bad | keep_zero;
    err_acc_d = err_acc_q;
    if (accept) err_acc_d = s_axis_tlast ? 1'b0 : (err_acc_q | s_axis_tuser | keep_bad);
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_resetn) err_acc_q <= 1'b0;
    else            err_acc_q <= err_acc_d;
  end
`else
  assign keep_zero = 1'b0;
  assign err_eop   = 1'b0;
`endif

  // Framing: B valid bytes end in segment (B-1)/16 with (-B mod 16) empty bytes.
  always_comb begin
    nbytes = 7'($countones(s_axis_tkeep));
    eseg   = 2'((nbytes - 7'd1) >> 4);
    emty   = 4'(7'd0 - nbytes);
    if (keep_zero) begin
      eseg = 2'd0;
      emty = 4'd15;
    end
    word_d = '0;
    for (int n = 0; n < LBUS_SEG_CNT; n++) begin
      if (!s_axis_tlast || n <= int'(eseg)) begin
        word_d[n].ena = 1'b1;
        for (int k = 0; k < LBUS_SEG_BYTES; k++)
          word_d[n].data[127-8*k -: 8] = s_axis_tdata[8*(LBUS_SEG_BYTES*n+k) +: 8];
        if (s_axis_tlast && n == int'(eseg)) begin
          word_d[n].eop = 1'b1;
          word_d[n].mty = emty;
          word_d[n].err = err_eop;
        end
      end
    end
    word_d[0].sop = !in_pkt_q;
  end

  always_comb begin
    in_pkt_d = accept ? !s_axis_tlast : in_pkt_q;
    lbus_d   = pop ? fifo_dout : '0;
  end

  lbus_tx_skid_fifo #(
    .DEPTH  (SKID_DEPTH),
    .word_t (lbus_word_t)
  ) u_skid (
    .clk_i   (tx_clk),
    .rst_ni  (tx_resetn),
    .push_i  (accept),
    .din_i   (word_d),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge tx_clk) begin
    if (!tx_resetn) begin
      lbus_q   <= '0;
      in_pkt_q <= 1'b0;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      lbus_q   <= lbus_d;
      in_pkt_q <= in_pkt_d;
      active_q <= 1'b1;
      ovf_q    <= ovf_q | tx_ovfout;
      unf_q    <= unf_q | tx_unfout;
    end
  end

  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;

  assign tx_datain0 = lbus_q[0].data;
  assign tx_enain0  = lbus_q[0].ena;
  assign tx_sopin0  = lbus_q[0].sop;
  assign tx_eopin0  = lbus_q[0].eop;
  assign tx_errin0  = lbus_q[0].err;
  assign tx_mtyin0  = lbus_q[0].mty;
  assign tx_datain1 = lbus_q[1].data;
  assign tx_enain1  = lbus_q[1].ena;
  assign tx_sopin1  = lbus_q[1].sop;
  assign tx_eopin1  = lbus_q[1].eop;
  assign tx_errin1  = lbus_q[1].err;
  assign tx_mtyin1  = lbus_q[1].mty;
  assign tx_datain2 = lbus_q[2].data;
  assign tx_enain2  = lbus_q[2].ena;
  assign tx_sopin2  = lbus_q[2].sop;
  assign tx_eopin2  = lbus_q[2].eop;
  assign tx_errin2  = lbus_q[2].err;
  assign tx_mtyin2  = lbus_q[2].mty;
  assign tx_datain3 = lbus_q[3].data;
  assign tx_enain3  = lbus_q[3].ena;
  assign tx_sopin3  = lbus_q[3].sop;
  assign tx_eopin3  = lbus_q[3].eop;
  assign tx_errin3  = lbus_q[3].err;
  assign tx_mtyin3  = lbus_q[3].mty;

endmodule

// File: tb/tb_axi_to_lbus.sv
// Randomized scoreboard bench for axi_to_lbus with a byte-level packet model.
module tb_axi_to_lbus;

  localparam int SKID_DEPTH = 4;
`ifdef AXI_TO_LBUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         tx_clk = 1'b0;
  logic         tx_resetn;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
`ifdef AXI_TO_LBUS_ERR_EN
  logic         s_axis_tuser;
`endif
  logic         tx_rdyout, tx_ovfout, tx_unfout;
  logic [127:0] tx_datain0, tx_datain1, tx_datain2, tx_datain3;
  logic         tx_enain0, tx_enain1, tx_enain2, tx_enain3;
  logic         tx_sopin0, tx_sopin1, tx_sopin2, tx_sopin3;
  logic         tx_eopin0, tx_eopin1, tx_eopin2, tx_eopin3;
  logic         tx_errin0, tx_errin1, tx_errin2, tx_errin3;
  logic [3:0]   tx_mtyin0, tx_mtyin1, tx_mtyin2, tx_mtyin3;
  logic         ovf_sticky, unf_sticky;

  axi_to_lbus #(.SKID_DEPTH(SKID_DEPTH)) dut (
    .tx_clk(tx_clk), .tx_resetn(tx_resetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
`ifdef AXI_TO_LBUS_ERR_EN
    .s_axis_tuser(s_axis_tuser),
`endif
    .tx_rdyout(tx_rdyout), .tx_ovfout(tx_ovfout), .tx_unfout(tx_unfout),
    .tx_datain0(tx_datain0), .tx_enain0(tx_enain0), .tx_sopin0(tx_sopin0),
    .tx_eopin0(tx_eopin0), .tx_errin0(tx_errin0), .tx_mtyin0(tx_mtyin0),
    .tx_datain1(tx_datain1), .tx_enain1(tx_enain1), .tx_sopin1(tx_sopin1),
    .tx_eopin1(tx_eopin1), .tx_errin1(tx_errin1), .tx_mtyin1(tx_mtyin1),
    .tx_datain2(tx_datain2), .tx_enain2(tx_enain2), .tx_sopin2(tx_sopin2),
    .tx_eopin2(tx_eopin2), .tx_errin2(tx_errin2), .tx_mtyin2(tx_mtyin2),
    .tx_datain3(tx_datain3), .tx_enain3(tx_enain3), .tx_sopin3(tx_sopin3),
    .tx_eopin3(tx_eopin3), .tx_errin3(tx_errin3), .tx_mtyin3(tx_mtyin3),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  always #5 tx_clk = ~tx_clk;

  // Expected word: bytes[i] is AXI byte i (zero where its segment is disabled).
  typedef struct packed {
    logic [63:0][7:0] bytes;
    logic [3:0]       ena, sop, eop, err;
    logic [3:0][3:0]  mty;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0, fails = 0, words_seen = 0;
  bit           m_in_pkt = 1'b0, m_err_acc = 1'b0, rdy_rand = 1'b0;
  logic         rdy_at_edge = 1'b1;
  logic [511:0] cur_data;
  logic [63:0]  cur_keep;
  logic         cur_last, cur_user;

  function automatic exp_t model_beat(logic [511:0] d, logic [63:0] keep, logic last,
                                      logic sop, logic err);
    exp_t e;
    int   b, nseg;
    e    = '0;
    b    = $countones(keep);
    nseg = last ? (b + 15) / 16 : 4;
    for (int n = 0; n < nseg; n++) begin
      e.ena[n] = 1'b1;
      for (int k = 0; k < 16; k++) e.bytes[16*n+k] = d[8*(16*n+k) +: 8];
    end
    e.sop[0] = sop;
    if (last) begin
      e.eop[nseg-1] = 1'b1;
      e.mty[nseg-1] = 4'(16*nseg - b);
      e.err[nseg-1] = err;
    end
    return e;
  endfunction

  function automatic logic [511:0] rand_data(int b);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
    for (int i = b; i < 64; i++) d[8*i +: 8] = 8'h00;
    return d;
  endfunction

  function automatic logic [63:0] keep_of(int b);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < b; i++) k[i] = 1'b1;
    return k;
  endfunction

  always @(posedge tx_clk) rdy_at_edge <= tx_rdyout;

  always @(negedge tx_clk) begin
    exp_t e, a;
    logic [127:0] sd [4];
    if (tx_resetn && (tx_enain0 | tx_enain1 | tx_enain2 | tx_enain3)) begin
      words_seen++;
      checks++;
      if (rdy_at_edge !== 1'b1) begin
        fails++;
        $display("FAIL emit_after_rdy0 got=word_emitted want=no_word");
      end
      sd[0] = tx_datain0; sd[1] = tx_datain1; sd[2] = tx_datain2; sd[3] = tx_datain3;
      a = '0;
      a.ena = {tx_enain3, tx_enain2, tx_enain1, tx_enain0};
      a.sop = {tx_sopin3, tx_sopin2, tx_sopin1, tx_sopin0};
      a.eop = {tx_eopin3, tx_eopin2, tx_eopin1, tx_eopin0};
      a.err = {tx_errin3, tx_errin2, tx_errin1, tx_errin0};
      a.mty = {tx_mtyin3, tx_mtyin2, tx_mtyin1, tx_mtyin0};
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 16; k++) a.bytes[16*n+k] = sd[n][127-8*k -: 8];
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL word%0d unexpected got=ena%b want=no_word", words_seen, a.ena);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL word%0d got ena=%b sop=%b eop=%b err=%b mty=%h data=%h want ena=%b sop=%b eop=%b err=%b mty=%h data=%h",
                   words_seen, a.ena, a.sop, a.eop, a.err, a.mty, a.bytes,
                   e.ena, e.sop, e.eop, e.err, e.mty, e.bytes);
        end
      end
    end
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
    if (rdy_rand) tx_rdyout = ($urandom_range(0, 3) != 0);
  endtask

  task automatic on_accept();
    bit e;
    e = m_err_acc | cur_user;
    exp_q.push_back(model_beat(cur_data, cur_keep, cur_last, !m_in_pkt, ERR_EN && e));
    m_err_acc = cur_last ? 1'b0 : e;
    m_in_pkt  = !cur_last;
  endtask

  task automatic prep_beat(input logic [511:0] d, input logic [63:0] keep,
                           input logic last, input logic user);
    cur_data = d; cur_keep = keep; cur_last = last; cur_user = user;
    s_axis_tdata = d; s_axis_tkeep = keep; s_axis_tlast = last; s_axis_tvalid = 1'b1;
`ifdef AXI_TO_LBUS_ERR_EN
    s_axis_tuser = user;
`endif
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] keep,
                           input logic last, input logic user);
    bit acc;
    acc = 1'b0;
    prep_beat(d, keep, last, user);
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = s_axis_tready;
      tick();
      if (acc) on_accept();
    end
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic send_pkt(input int len, input int user_beat);
    int nb;
    nb = (len + 63) / 64;
    for (int i = 0; i < nb; i++) begin
      int b;
      b = (i == nb - 1) ? len - 64 * i : 64;
      send_beat(rand_data(b), keep_of(b), i == nb - 1, i == user_beat);
      if (rdy_rand && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    tx_resetn = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    m_in_pkt = 1'b0;
    m_err_acc = 1'b0;
    repeat (3) tick();
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_ena", {tx_enain3, tx_enain2, tx_enain1, tx_enain0}, 0);
    chk("rst_flags", {tx_sopin0, tx_eopin3, tx_errin0, tx_mtyin3, tx_mtyin2}, 0);
    chk("rst_data0", tx_datain0 | tx_datain1 | tx_datain2 | tx_datain3, 0);
    chk("rst_sticky", {ovf_sticky, unf_sticky}, 0);
    tx_resetn = 1'b1;
    tick();
    chk("tready_after_rst", s_axis_tready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running want=finished");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt, ws, beat;
    bit acc;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
`ifdef AXI_TO_LBUS_ERR_EN
    s_axis_tuser = 1'b0;
`endif
    tx_rdyout = 1'b1; tx_ovfout = 1'b0; tx_unfout = 1'b0; tx_resetn = 1'b0;
    do_reset();

    // 64-byte single beat, also measuring minimum latency
    send_beat(rand_data(64), keep_of(64), 1'b1, 1'b0);
    tick();
    chk("latency_edge1_ena0", tx_enain0, 0);
    tick();
    chk("latency_edge2_ena0", tx_enain0, 1);
    wait_drain();

    send_pkt(100, -1);
    send_pkt(1, -1);
    wait_drain();

    // MAC stalls for 10 cycles while an 8-beat packet is offered
    tx_rdyout = 1'b0;
    ws = words_seen;
    acc_cnt = 0;
    beat = 0;
    prep_beat(rand_data(64), keep_of(64), 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      acc = s_axis_tready;
      tick();
      if (acc) begin
        on_accept();
        acc_cnt++;
        beat++;
        prep_beat(rand_data(64), keep_of(64), beat == 7, 1'b0);
      end
    end
    s_axis_tvalid = 1'b0;
    chk("stall_accepted", acc_cnt, SKID_DEPTH);
    chk("stall_words_out", words_seen - ws, 0);
    tx_rdyout = 1'b1;
    for (int i = beat; i < 8; i++) send_beat(rand_data(64), keep_of(64), i == 7, 1'b0);
    wait_drain();

    rdy_rand = 1'b1;
    for (int p = 0; p < 25; p++) send_pkt($urandom_range(1, 300), -1);
    rdy_rand = 1'b0;
    tx_rdyout = 1'b1;
    wait_drain();

`ifdef AXI_TO_LBUS_ERR_EN
    send_pkt(150, 0);
    send_pkt(70, -1);
    wait_drain();
`endif

    tx_ovfout = 1'b1; tick(); tx_ovfout = 1'b0; tick(); tick();
    chk("sticky_after_ovf", {ovf_sticky, unf_sticky}, 2'b10);
    tx_unfout = 1'b1; tick(); tx_unfout = 1'b0; tick(); tick();
    chk("sticky_after_unf", {ovf_sticky, unf_sticky}, 2'b11);

    // reset right after the first beat of a 3-beat packet
    tick();
    send_beat(rand_data(64), keep_of(64), 1'b0, 1'b0);
    do_reset();
    send_pkt(10, -1);
    send_pkt(130, -1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
